vector_distance_seq: RTL and testbench
======================================

VECTOR_DISTANCE_SEQ -- requirements
Module: vector_distance_seq

Interface
REQ-001 The block SHALL have the parameter VECTOR_LEN, defaulting to the VECTOR_LEN value in GAM_package, which sets the number of elements per vector; the legal range is 1..1024.
REQ-002 The block SHALL have the parameter array_length, default 8; each element is a signed value of array_length+1 bits.
REQ-003 The block SHALL use one clock, with reset asynchronous and active-low.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port in_valid, input, 1 bit: an element pair is present.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block can accept an element pair.
REQ-008 The block SHALL have ports in_a and in_b, input, array_length+1 bits, signed: the element pair.
REQ-009 The block SHALL have port abort, input, 1 bit: synchronous cancel.
REQ-010 The block SHALL have port out_valid, output, 1 bit: a result is present.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-012 The block SHALL have port out_sum_sq, output, 32 bits, unsigned: sum of (a-b)^2 over the vector.
REQ-013 The block SHALL have port out_dist, output, 16 bits, unsigned: floor(sqrt(out_sum_sq)).
REQ-014 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-015 The state machine SHALL have exactly four states: IDLE, ACCUM, SQRT and DONE.
REQ-016 in_ready SHALL be 1 in IDLE and ACCUM, and 0 in SQRT and DONE.
REQ-017 An element pair SHALL be accepted on a rising edge where in_valid and in_ready are both 1.
REQ-018 On each accept, the block SHALL form the difference in_a-in_b at array_length+2 bits signed, square it exactly (unsigned), and add it to a 32-bit accumulator; no truncation is permitted.
REQ-019 In IDLE, the first accept SHALL load the accumulator with that square, set the element counter to 1, and move the state to ACCUM; if VECTOR_LEN==1, the state SHALL move directly to SQRT instead.
REQ-020 In ACCUM, the accept that brings the counter to VECTOR_LEN SHALL move the state to SQRT and reset the counter to 0.
REQ-021 In SQRT, the block SHALL run a bit-serial restoring integer square root, one result bit per cycle, MSB first, over exactly 16 cycles.
REQ-022 After the 16th SQRT edge, the block SHALL enter DONE.
REQ-023 Latency: out_valid SHALL rise after the 16th rising edge following the edge that accepted the last element.
REQ-024 In DONE, out_valid SHALL be 1, and out_dist and out_sum_sq SHALL be stable until the handshake edge.
REQ-025 In DONE with out_valid and out_ready both 1 at an edge, the state SHALL move to IDLE and out_valid SHALL be 0 after that edge.
REQ-026 out_sum_sq and out_dist SHALL hold their last values until the next DONE.
REQ-027 No input SHALL be accepted in the cycle that the DONE handshake occurs, because in_ready is 0 in DONE.
REQ-028 abort=1 at a rising edge SHALL force the state to IDLE and clear the counter and accumulator, with priority over every other event, including a simultaneous accept or DONE handshake.
REQ-029 An abort SHALL leave out_dist and out_sum_sq unchanged and SHALL drive out_valid to 0.
REQ-030 abort asserted while in IDLE SHALL have no effect.
REQ-031 With VECTOR_LEN at most 1024 and the maximum square of 261121, the accumulator SHALL never overflow, and no overflow flag is required.
REQ-032 Gaps in in_valid during ACCUM SHALL stall accumulation without losing or duplicating elements.

Reset
REQ-033 Asserting rst_n=0 SHALL asynchronously force the state to IDLE, the counter and accumulator to 0, out_valid=0, out_dist=0, out_sum_sq=0 and busy=0; in_ready SHALL be 1 while rst_n is low.
REQ-034 A reset asserted mid-ACCUM or mid-SQRT SHALL discard the partial result.
REQ-035 After rst_n deasserts, the first element pair SHALL be accepted on the first rising edge at which in_valid=1.

Verification (VECTOR_LEN=4)
REQ-036 Stimulus: pairs (3,0),(0,4),(0,0),(0,0). Required response: out_sum_sq=25, out_dist=5, with out_valid rising 16 edges after the 4th accept.
REQ-037 Stimulus: four pairs of (255,-256). Required response: out_sum_sq=1044484, out_dist=1022 (extreme widths, no truncation).
REQ-038 Stimulus: pairs (1,0),(0,1),(2,0),(-4,0), giving sum 22. Required response: out_dist=4 (non-perfect square floors).
REQ-039 Stimulus: out_ready held at 0 for 10 cycles in DONE while in_valid=1. Required response: outputs stay stable, in_ready stays 0, and exactly one handshake follows, after which the block is back in IDLE.
REQ-040 Stimulus: abort after 2 accepts, then a fresh vector of all pairs (1,0). Required response: out_sum_sq=4, out_dist=2, with no contribution from the aborted elements.
REQ-041 Stimulus: rst_n pulsed low mid-SQRT, then a vector of all pairs (0,0). Required response: all outputs 0 immediately on reset, then out_sum_sq=0, out_dist=0, and out_valid rising 16 edges after the last accept.

Source files
------------

// File: rtl/vector_distance_seq.sv
// ---------------------------------------------------------------------------
// vector_distance_seq
//
// Purpose:
//   Streams VECTOR_LEN signed element pairs (a, b), accumulates the exact
//   sum of squared differences sum((a-b)^2) in 32 bits, then computes
//   floor(sqrt(sum)) with a 16-cycle bit-serial restoring square root.
//
// Ports:
//   clk         in   1      rising-edge clock
//   rst_n       in   1      asynchronous active-low reset
//   in_valid    in   1      element pair present
//   in_ready    out  1      block can accept an element pair (IDLE/ACCUM)
//   in_a, in_b  in   AL+1   signed element pair (AL = array_length)
//   abort       in   1      synchronous cancel, highest priority
//   out_valid   out  1      result present (DONE state)
//   out_ready   in   1      consumer accepts the result
//   out_sum_sq  out  32     sum of (a-b)^2 over the vector
//   out_dist    out  16     floor(sqrt(out_sum_sq))
//   busy        out  1      state is not IDLE
//   dbg_state   out  2      current FSM state (0 IDLE, 1 ACCUM, 2 SQRT, 3 DONE)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. Neither ready depends combinationally on the matching valid;
// in_ready and out_valid are pure decodes of the registered state.
// ---------------------------------------------------------------------------
package GAM_package;
    parameter int VECTOR_LEN = 4;
endpackage

module vector_distance_seq #(
    parameter int VECTOR_LEN   = GAM_package::VECTOR_LEN,
    parameter int array_length = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [array_length:0] in_a,
    input  logic signed [array_length:0] in_b,
    input  logic                      abort,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [31:0]               out_sum_sq,
    output logic [15:0]               out_dist,
    output logic                      busy,
    output logic [1:0]                dbg_state
);

    localparam int EW = array_length + 1;   // element width
    localparam int DW = array_length + 2;   // difference width
    localparam int CW = (VECTOR_LEN < 2) ? 1 : $clog2(VECTOR_LEN + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_SQRT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [31:0]   r_acc;
    logic [31:0]   r_rad;     // radicand, shifted left two bits per SQRT cycle
    logic [17:0]   r_rem;     // partial remainder, never exceeds 2*root
    logic [15:0]   r_root;
    logic [3:0]    r_bit;
    logic [31:0]   r_sum;
    logic [15:0]   r_dist;

    // Difference at one extra bit so extreme operands cannot wrap; its
    // magnitude is then widened to 32 bits before squaring.
    logic signed [DW-1:0] w_diff;
    logic [DW-1:0]        w_abs;
    logic [31:0]          w_abs32;
    logic [31:0]          w_sq32;
    logic [31:0]          w_acc_sum;
    logic [CW-1:0]        w_cnt_inc;
    logic                 w_accept;

    assign w_diff    = $signed({in_a[EW-1], in_a}) - $signed({in_b[EW-1], in_b});
    assign w_abs     = w_diff[DW-1] ? DW'(-w_diff) : DW'(w_diff);
    assign w_abs32   = 32'(w_abs);
    assign w_sq32    = w_abs32 * w_abs32;
    assign w_acc_sum = r_acc + w_sq32;
    assign w_cnt_inc = r_cnt + 1'b1;
    assign w_accept  = in_valid & in_ready;

    // One restoring square-root step: bring down the next two radicand bits
    // and try to subtract (4*root + 1).
    logic [19:0] w_rem_shift;
    logic [19:0] w_trial;
    logic        w_fits;
    logic [19:0] w_rem_next;
    logic [15:0] w_root_next;

    assign w_rem_shift = {r_rem, r_rad[31:30]};
    assign w_trial     = {2'b00, r_root, 2'b01};
    assign w_fits      = (w_rem_shift >= w_trial);
    assign w_rem_next  = w_fits ? (w_rem_shift - w_trial) : w_rem_shift;
    assign w_root_next = {r_root[14:0], w_fits};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_rad   <= '0;
            r_rem   <= '0;
            r_root  <= '0;
            r_bit   <= '0;
            r_sum   <= '0;
            r_dist  <= '0;
        end else if (abort) begin
            // Results of the previous vector are deliberately kept.
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_acc   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_acc <= w_sq32;
                        if (VECTOR_LEN == 1) begin
                            r_state <= S_SQRT;
                            r_cnt   <= '0;
                            r_rad   <= w_sq32;
                            r_rem   <= '0;
                            r_root  <= '0;
                            r_bit   <= '0;
                        end else begin
                            r_state <= S_ACCUM;
                            r_cnt   <= CW'(1);
                        end
                    end
                end
                S_ACCUM: begin
                    if (w_accept) begin
                        r_acc <= w_acc_sum;
                        if (w_cnt_inc == CW'(VECTOR_LEN)) begin
                            r_state <= S_SQRT;
                            r_cnt   <= '0;
                            r_rad   <= w_acc_sum;
                            r_rem   <= '0;
                            r_root  <= '0;
                            r_bit   <= '0;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                end
                S_SQRT: begin
                    r_rad  <= {r_rad[29:0], 2'b00};
                    r_rem  <= 18'(w_rem_next);
                    r_root <= w_root_next;
                    r_bit  <= r_bit + 4'd1;
                    if (r_bit == 4'd15) begin
                        r_state <= S_DONE;
                        r_dist  <= w_root_next;
                        r_sum   <= r_acc;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready   = (r_state == S_IDLE) || (r_state == S_ACCUM);
    assign out_valid  = (r_state == S_DONE);
    assign busy       = (r_state != S_IDLE);
    assign out_sum_sq = r_sum;
    assign out_dist   = r_dist;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_vector_distance_seq.sv
module tb_vector_distance_seq;

    localparam int VL = 4;
    localparam int AL = 8;

    // ---------------- clock / reset / DUT ----------------
    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic signed [AL:0] in_a;
    logic signed [AL:0] in_b;
    logic              abort;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_sum_sq;
    logic [15:0]       out_dist;
    logic              busy;
    logic [1:0]        dbg_state;

    always #5 clk = ~clk;

    vector_distance_seq #(.VECTOR_LEN(VL), .array_length(AL)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .abort     (abort),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum_sq(out_sum_sq),
        .out_dist  (out_dist),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model + scoreboard ----------------
    int n_vec = 0;
    int n_chk = 0;
    int n_err = 0;
    int va[VL];
    int vb[VL];
    logic [31:0] exp_q[$];   // expected {sum} values, pushed per vector

    function automatic longint ref_sum();
        longint s = 0;
        for (int i = 0; i < VL; i++) s += longint'(va[i] - vb[i]) * longint'(va[i] - vb[i]);
        return s;
    endfunction

    function automatic longint ref_isqrt(longint s);
        longint r = 0;
        while ((r + 1) * (r + 1) <= s) r++;
        return r;
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_pair(string tag, int a, int b, int gap);
        int w;
        in_valid = 1'b0;
        repeat (gap) tick();
        in_a     = (AL+1)'(a);
        in_b     = (AL+1)'(b);
        in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 200) begin
            tick();
            w++;
        end
        if (w >= 200) chk({tag, "_ready_timeout"}, in_ready, 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_all(string tag, int random_gaps);
        for (int i = 0; i < VL; i++)
            send_pair(tag, va[i], vb[i], random_gaps ? $urandom_range(0, 2) : 0);
        exp_q.push_back(32'(ref_sum()));
    endtask

    // Waits for the result, checks latency/values, holds out_ready low for
    // 'hold' cycles (optionally with in_valid high) and then handshakes.
    task automatic wait_result(string tag, int hold, int valid_in_hold);
        int n;
        logic [31:0] e_sum;
        logic [15:0] e_dist;
        e_sum  = exp_q.pop_front();
        e_dist = 16'(ref_isqrt(longint'(e_sum)));
        n = 0;
        while (!out_valid && n < 100) begin
            tick();
            n++;
        end
        chk({tag, "_latency"}, n, 16);
        chk({tag, "_out_valid"}, out_valid, 1);
        chk({tag, "_sum"}, out_sum_sq, e_sum);
        chk({tag, "_dist"}, out_dist, e_dist);
        chk({tag, "_in_ready_done"}, in_ready, 0);
        out_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            if (valid_in_hold != 0) begin
                in_valid = 1'b1;
                in_a = (AL+1)'($urandom_range(0, 511));
                in_b = (AL+1)'($urandom_range(0, 511));
            end
            tick();
            chk({tag, "_hold_valid"}, out_valid, 1);
            chk({tag, "_hold_ready"}, in_ready, 0);
            chk({tag, "_hold_sum"}, out_sum_sq, e_sum);
            chk({tag, "_hold_dist"}, out_dist, e_dist);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk({tag, "_post_hs_valid"}, out_valid, 0);
        chk({tag, "_post_hs_busy"}, busy, 0);
        tick();
        chk({tag, "_idle_busy"}, busy, 0);
        chk({tag, "_keep_sum"}, out_sum_sq, e_sum);
        n_vec++;
    endtask

    task automatic set_vec(int a0, int b0, int a1, int b1, int a2, int b2, int a3, int b3);
        va[0] = a0; vb[0] = b0; va[1] = a1; vb[1] = b1;
        va[2] = a2; vb[2] = b2; va[3] = a3; vb[3] = b3;
    endtask

    task automatic rand_vec();
        for (int i = 0; i < VL; i++) begin
            va[i] = int'($urandom_range(0, 511)) - 256;
            vb[i] = int'($urandom_range(0, 511)) - 256;
        end
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [31:0] keep_sum;
        logic [15:0] keep_dist;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        abort     = 1'b0;
        out_ready = 1'b0;
        repeat (3) tick();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sum", out_sum_sq, 0);
        chk("rst_dist", out_dist, 0);
        rst_n = 1'b1;

        // First pair accepted on the first edge with in_valid high.
        set_vec(3, 0, 0, 4, 0, 0, 0, 0);
        send_all("v036", 0);
        wait_result("v036", 0, 0);
        chk("v036_sum_const", out_sum_sq, 25);
        chk("v036_dist_const", out_dist, 5);

        set_vec(255, -256, 255, -256, 255, -256, 255, -256);
        send_all("v037", 1);
        wait_result("v037", 1, 0);
        chk("v037_sum_const", out_sum_sq, 1044484);
        chk("v037_dist_const", out_dist, 1022);

        set_vec(1, 0, 0, 1, 2, 0, -4, 0);
        send_all("v038", 1);
        wait_result("v038", 0, 0);
        chk("v038_dist_const", out_dist, 4);

        // Back-pressure in DONE with in_valid held high.
        rand_vec();
        send_all("v039", 0);
        wait_result("v039", 10, 1);

        // Abort after two accepts, colliding with a third in_valid.
        keep_sum  = out_sum_sq;
        keep_dist = out_dist;
        send_pair("v040", 9, -3, 0);
        send_pair("v040", 5, -6, 1);
        chk("v040_busy_mid", busy, 1);
        in_valid = 1'b1; in_a = 9'sd100; in_b = 9'sd0;
        abort    = 1'b1;
        tick();
        abort    = 1'b0;
        in_valid = 1'b0;
        chk("v040_abort_busy", busy, 0);
        chk("v040_abort_valid", out_valid, 0);
        chk("v040_abort_sum", out_sum_sq, keep_sum);
        chk("v040_abort_dist", out_dist, keep_dist);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("v040_idle_abort_busy", busy, 0);
        set_vec(1, 0, 1, 0, 1, 0, 1, 0);
        send_all("v040", 1);
        wait_result("v040", 2, 0);
        chk("v040_sum_const", out_sum_sq, 4);
        chk("v040_dist_const", out_dist, 2);

        // Abort colliding with a DONE handshake keeps the fresh results.
        rand_vec();
        send_all("vab", 0);
        begin
            int n = 0;
            while (!out_valid && n < 100) begin tick(); n++; end
            chk("vab_latency", n, 16);
        end
        keep_sum  = exp_q.pop_front();
        out_ready = 1'b1;
        abort     = 1'b1;
        tick();
        abort     = 1'b0;
        out_ready = 1'b0;
        chk("vab_valid", out_valid, 0);
        chk("vab_busy", busy, 0);
        chk("vab_sum", out_sum_sq, keep_sum);
        chk("vab_dist", out_dist, 16'(ref_isqrt(longint'(keep_sum))));
        n_vec++;

        // Reset mid-SQRT, then an all-zero vector.
        rand_vec();
        va[0] = 200; vb[0] = -100;
        send_all("v041a", 0);
        void'(exp_q.pop_front());
        repeat (5) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("v041_rst_valid", out_valid, 0);
        chk("v041_rst_busy", busy, 0);
        chk("v041_rst_ready", in_ready, 1);
        chk("v041_rst_sum", out_sum_sq, 0);
        chk("v041_rst_dist", out_dist, 0);
        tick();
        #1 rst_n = 1'b1;
        set_vec(0, 0, 0, 0, 0, 0, 0, 0);
        send_all("v041", 0);
        wait_result("v041", 0, 0);

        // Randomized vectors with input gaps and output back-pressure.
        for (int k = 0; k < 25; k++) begin
            rand_vec();
            if (k % 7 == 3) begin va[1] = -256; vb[1] = 255; end
            send_all("rnd", 1);
            wait_result("rnd", $urandom_range(0, 3), $urandom_range(0, 1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
